// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter
//   Shares one memory read port between NUM_REQ page-table walkers. Each walker
//   pulses req_valid once and later receives a one-cycle rsp_ready pulse. Requests
//   are latched into per-walker pend/addr_q slots and served one at a time, in
//   round-robin order. A walker may cancel with req_abort. A WAIT timeout turns a
//   hung memory port into an error response.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   req_valid    per-walker request pulse
//   req_addr     per-walker PTE address, slice i = [i*PADDR_WIDTH +: PADDR_WIDTH]
//   req_abort    per-walker cancel
//   rsp_ready    one-hot, one-cycle response pulse
//   rsp_err      error flag, qualified by rsp_ready
//   rsp_data     PTE, qualified by rsp_ready (0 otherwise)
//   mem_req      read request, held until mem_gnt
//   mem_addr     read address, 0 when mem_req is low
//   mem_gnt      memory accepts the request
//   mem_rvalid   read data valid
//   mem_rdata    read data
//   mem_err      bus error, qualified by mem_rvalid
//   busy         FSM active or any request pending
//   state_dbg    current FSM state (IDLE=0, REQ=1, WAIT=2, RESP=3)
//
// Handshake: req_valid is a single-cycle pulse. A walker has at most one request
// in flight, and the pulse is ignored while that walker is still pending.
// mem_req/mem_addr are held stable until the cycle in which mem_gnt is high.
// Exactly one read is outstanding at a time, and its data returns with mem_rvalid.
module ptw_mem_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int PADDR_WIDTH = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             req_abort,
  output logic [NUM_REQ-1:0]             rsp_ready,
  output logic [NUM_REQ-1:0]             rsp_err,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           mem_req,
  output logic [PADDR_WIDTH-1:0]         mem_addr,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_err,
  output logic                           busy,
  output logic [1:0]                     state_dbg
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t                   state, state_nx;
  logic [NUM_REQ-1:0]       pend;
  logic [PADDR_WIDTH-1:0]   addr_q [NUM_REQ];
  logic [IW-1:0]            gidx, rr_ptr, pick;
  logic                     pick_vld;
  logic [NUM_REQ-1:0]       eligible;
  logic [CW-1:0]            cnt;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     err_q, kill, timeout_hit;

  // (base + k) modulo NUM_REQ, for k in [0, NUM_REQ]
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Round-robin pick: the walk runs downward so the lowest offset from rr_ptr wins.
  // A walker aborting this very cycle is not eligible, so nothing is granted to a
  // slot that is being cleared on the same edge.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    eligible = pend & ~req_abort;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[wrap_add(rr_ptr, k)]) begin
        pick     = wrap_add(rr_ptr, k);
        pick_vld = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    rsp_ready = '0;
    rsp_err   = '0;
    rsp_data  = '0;
    case (state)
      IDLE: if (pick_vld) state_nx = REQ;
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = addr_q[gidx];
        if (mem_gnt) state_nx = WAIT;
      end
      WAIT: if (mem_rvalid || timeout_hit) state_nx = RESP;
      RESP: begin
        // A killed transaction still passes through RESP, but it stays silent.
        if (!kill) begin
          rsp_ready[gidx] = 1'b1;
          rsp_err[gidx]   = err_q;
          rsp_data        = data_q;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      kill   <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) addr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_abort[i]) begin
          // The granted walker keeps its slot until RESP; its abort becomes kill below.
          if (!((state != IDLE) && (gidx == IW'(i)))) pend[i] <= 1'b0;
        end else if (req_valid[i] && !pend[i]) begin
          pend[i]   <= 1'b1;
          addr_q[i] <= req_addr[i*PADDR_WIDTH +: PADDR_WIDTH];
        end
      end
      case (state)
        IDLE: if (pick_vld) begin
          gidx   <= pick;
          rr_ptr <= wrap_add(pick, 1);
        end
        REQ: if (mem_gnt) cnt <= '0;
        WAIT: begin
          if (mem_rvalid) begin
            data_q <= mem_rdata;
            err_q  <= mem_err;
          end else if (timeout_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          pend[gidx] <= 1'b0;
          kill       <= 1'b0;
        end
        default: ;
      endcase
      if ((state == REQ || state == WAIT) && req_abort[gidx]) kill <= 1'b1;
    end
  end

  assign busy      = (state != IDLE) || (|pend);
  assign state_dbg = state;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Bench for ptw_mem_arbiter. It runs directed scenarios followed by random
// traffic. The reference model works at the transaction level: pending request
// sets, a round-robin pointer, and an edge counter that measures WAIT length.
// It pushes the expected responses into exp_q. A negedge monitor pops exp_q and
// compares the result against the DUT pins.
module tb_ptw_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam int RW = 2 * N + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_abort = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_data;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy;
  logic [1:0]      state_dbg;

  ptw_mem_arbiter #(.NUM_REQ(N), .PADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_abort(req_abort),
    .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ph_m: 0 no transaction, 1 address phase, 2 data phase, 3 response cycle
  bit            pend_m [N];
  logic [AW-1:0] addr_m [N];
  int            rr_m = 0, owner_m = 0, ph_m = 0, wait_start = 0, edge_no = 0;
  bit            kill_m = 0, e_m = 0;
  logic [DW-1:0] d_m = '0;

  task automatic model_edge();
    int  old_ph;
    bit  found;
    logic [N-1:0] rdy;
    edge_no++;
    if (rst) begin
      for (int i = 0; i < N; i++) pend_m[i] = 0;
      rr_m = 0; ph_m = 0; owner_m = 0; kill_m = 0;
      exp_q.delete();
      return;
    end
    old_ph = ph_m;
    case (old_ph)
      0: begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          int w;
          w = (rr_m + k) % N;
          if (!found && pend_m[w] && !req_abort[w]) begin owner_m = w; found = 1; end
        end
        if (found) begin rr_m = (owner_m + 1) % N; ph_m = 1; end
      end
      1: if (mem_gnt) begin ph_m = 2; wait_start = edge_no; end
      2: begin
        if (mem_rvalid) begin d_m = mem_rdata; e_m = mem_err; ph_m = 3; end
        else if (TO > 0 && edge_no - wait_start == TO) begin d_m = '0; e_m = 1; ph_m = 3; end
      end
      default: ph_m = 0;
    endcase
    for (int i = 0; i < N; i++) begin
      if (req_abort[i]) begin
        if (old_ph != 0 && i == owner_m) begin
          if (old_ph != 3) kill_m = 1;
        end else pend_m[i] = 0;
      end else if (req_valid[i] && !pend_m[i]) begin
        pend_m[i] = 1;
        addr_m[i] = req_addr[i*AW +: AW];
      end
    end
    if (old_ph == 3) begin pend_m[owner_m] = 0; kill_m = 0; end
    if (ph_m == 3 && !kill_m) begin
      rdy = '0;
      rdy[owner_m] = 1'b1;
      exp_q.push_back({rdy, e_m ? rdy : {N{1'b0}}, d_m});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [RW-1:0] ex;
    logic [AW-1:0] ex_addr;
    bit            ex_busy;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk("rsp", {rsp_ready, rsp_err, rsp_data}, ex);
    end else begin
      chk("rsp_quiet", {rsp_ready, rsp_err, rsp_data}, '0);
    end
    ex_addr = (ph_m == 1) ? addr_m[owner_m] : '0;
    chk("mem_req", {mem_req, mem_addr}, {(ph_m == 1), ex_addr});
    ex_busy = (ph_m != 0);
    for (int i = 0; i < N; i++) if (pend_m[i]) ex_busy = 1;
    chk("busy", busy, ex_busy);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic quiet();
    req_valid = '0; req_abort = '0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1; tick(2); rst = 0;
  endtask

  task automatic pulse(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    req_valid = v;
    req_addr[0 +: AW]  = a0;
    req_addr[AW +: AW] = a1;
    tick(1);
    req_valid = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] held;
    do_reset();
    chk("reset_outs", {rsp_ready, rsp_err, rsp_data, mem_req, mem_addr, busy}, '0);

    // T1 single request, minimum latency
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'hA5A5_0000_0000_2001;
    pulse(2'b01, 64'h8000_1000, 64'h0);
    tick(3);
    chk("t1_ready", rsp_ready, 2'b01);
    chk("t1_data", rsp_data, 64'hA5A5_0000_0000_2001);
    chk("t1_err", rsp_err, 2'b00);
    tick(2);

    // T2 contention, then round-robin order
    do_reset();
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = {$urandom(), $urandom()};
    pulse(2'b11, 64'h100, 64'h200);
    tick(1);
    chk("t2_first", mem_addr, 64'h100);
    tick(4);
    chk("t2_second", mem_addr, 64'h200);
    tick(6);
    pulse(2'b01, 64'h300, 64'h0);
    tick(6);
    pulse(2'b11, 64'h400, 64'h500);
    tick(1);
    chk("t2_rr_w1", mem_addr, 64'h500);
    tick(10);

    // T3 abort of a waiting walker, then abort of the granted walker in WAIT
    do_reset();
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'h1234;
    pulse(2'b11, 64'h600, 64'h700);
    req_abort = 2'b10; tick(1); req_abort = '0;
    tick(12);
    mem_rvalid = 0;
    pulse(2'b01, 64'h800, 64'h0);
    tick(2);
    req_abort = 2'b01; tick(1); req_abort = '0;
    mem_rvalid = 1; tick(1);
    chk("t3_killed", rsp_ready, 2'b00);
    tick(3);

    // T4 timeout, late rvalid dropped
    do_reset();
    mem_gnt = 1; mem_rvalid = 0;
    pulse(2'b01, 64'h900, 64'h0);
    tick(10);
    chk("t4_ready", rsp_ready, 2'b01);
    chk("t4_err", rsp_err, 2'b01);
    chk("t4_data", rsp_data, 64'h0);
    mem_rvalid = 1; tick(3); mem_rvalid = 0;

    // T5 grant stall with stable address, then bus error
    do_reset();
    mem_gnt = 0;
    pulse(2'b10, 64'h0, 64'hABC0);
    tick(1);
    held = mem_addr;
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_req", mem_req, 1'b1);
      chk("t5_stall_addr", mem_addr, held);
      tick(1);
    end
    chk("t5_addr_val", held, 64'hABC0);
    mem_gnt = 1; tick(1);
    mem_rvalid = 1; mem_err = 1; mem_rdata = 64'h55; tick(1);
    chk("t5_err", {rsp_ready, rsp_err}, 4'b1010);
    quiet(); tick(2);

    // T6 reset while waiting for data
    do_reset();
    mem_gnt = 1;
    pulse(2'b01, 64'hC00, 64'h0);
    tick(3);
    rst = 1; tick(1); rst = 0;
    chk("t6_outs", {rsp_ready, rsp_err, rsp_data, mem_req, mem_addr, busy}, '0);
    mem_rvalid = 1; tick(4);
    chk("t6_no_rsp", rsp_ready, 2'b00);
    quiet(); tick(1);

    // random traffic, alternating fast and slow memory
    for (int blk = 0; blk < 6; blk++) begin
      int rv_pct;
      rv_pct = (blk % 2 == 1) ? 5 : 60;
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < N; i++) begin
          req_valid[i] = ($urandom_range(99) < 20);
          req_abort[i] = ($urandom_range(99) < 4);
          req_addr[i*AW +: AW] = {$urandom(), $urandom()};
        end
        mem_gnt    = ($urandom_range(99) < 50);
        mem_rvalid = ($urandom_range(99) < rv_pct);
        mem_rdata  = {$urandom(), $urandom()};
        mem_err    = ($urandom_range(99) < 10);
        rst        = ($urandom_range(999) == 0);
        tick(1);
      end
    end
    rst = 0; quiet(); tick(30);

    chk("queue_drained", 128'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
